multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit: a clocked FSM that sequences one instruction over several cycles (fetch, decode, execute, memory, writeback) and drives the shared-ALU, single-memory datapath. It decodes the same ISA as the single-cycle decoder, including the status-flag branches (BZ/BN and their link forms). It adds a variable-latency memory handshake, a wait timeout and a fault state. It sits between the instruction register, memory port and register file of the multicycle processor.

## Interface
- WIDTH, 32: instruction width; opcode is [WIDTH-1:WIDTH-6], func is [5:0].
- TIMEOUT, 255: maximum consecutive memory wait cycles before fault; 0 disables the timeout.
- STATUS_BR, 1: 1 enables the status-flag branch opcodes; 0 decodes them as illegal.
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- instr  in  WIDTH  instruction register contents, valid from DECODE onward.
- mem_ready  in  1  memory completes the current request in this cycle.
- alu_zero  in  1  ALU zero flag.
- st_z, st_n  in  1 each  status register Z and N flags.
- mem_req, mem_we, iord  out  1 each  memory request, write enable, and address select (0 = PC, 1 = ALUOut).
- ir_write, pc_write  out  1 each  IR load and PC load strobes.
- reg_write, reg_dst, write_reg31, link, mem_to_reg, ext_op  out  1 each  register-file and immediate controls; meanings as in the single-cycle decoder.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- alu_op  out  3  `OP_*` code.
- pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump field, 11 = rs.
- state  out  3  current state.
- illegal, timeout  out  1 each  sticky fault causes.

## Operation
- States and codes: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 5. Codes 6 and 7 go to FAULT on the next edge.
- Outputs are combinational from state, instr and flags. Any output not listed for a state is 0, and alu_op defaults to `OP_ADD`.
- **FETCH**
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 00, then go to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - alu_src_b = 11, ext_op = 1; the branch target is latched into ALUOut by the datapath.
  - J/JAL: pc_write = 1, pc_src = 10, then FETCH. JAL also asserts reg_write, write_reg31 and link.
  - JR/JALR: pc_write = 1, pc_src = 11, then FETCH. JALR also asserts reg_write and link.
  - Opcode or func not in `_const.v`: illegal = 1, go to FAULT.
  - All other instructions go to EXEC.
- **EXEC**
  - R-type ALU: alu_src_a = 1, alu_src_b = 00, alu_op from func, then WB.
  - ADDI/ANDI/ORI: alu_src_a = 1, alu_src_b = 10. ext_op = 1 only for ADDI. Then WB.
  - LW/SW: alu_src_a = 1, alu_src_b = 10, ext_op = 1, then MEM.
  - BEQ/BNE: alu_src_a = 1, alu_src_b = 00, alu_op = `OP_SUB`, pc_src = 01. pc_write = (alu_zero == 1 for BEQ, == 0 for BNE). Then FETCH.
  - BZ/BN (including link forms): pc_src = 01, pc_write = (st_z for Z forms, st_n for N forms). Link forms assert reg_write, write_reg31 and link only when the branch is taken. Then FETCH.
- **MEM**
  - mem_req = 1, iord = 1, mem_we = 1 for SW.
  - On mem_ready: SW goes to FETCH, LW goes to WB. Otherwise stay in MEM.
- **WB**
  - reg_write = 1. reg_dst = 0 for R-type and 1 for I-type/LW. mem_to_reg = 1 for LW.
  - Then FETCH.
- **FAULT**
  - Absorbing state; all strobes are 0. Only reset leaves it.
- **Wait counter**
  - Width is clog2(TIMEOUT+1). It increments each cycle with mem_req = 1 and mem_ready = 0, and clears on completion or on any state change.
  - When the counter equals TIMEOUT - 1 and mem_ready = 0, the next state is FAULT and timeout is set.
  - mem_ready arriving in that same cycle wins: no fault.

## Timing
- Reset: state = FETCH, counter = 0, illegal = 0, timeout = 0. While reset is high, every strobe output is forced to 0.
- Cycle counts with zero-wait memory (mem_ready high in the request cycle):
  - J/JR/JAL/JALR: 2 cycles.
  - BEQ/BNE/status branches: 3 cycles.
  - R-type, I-type ALU, SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds 1 cycle to FETCH or MEM.
- Handshake: a request completes in the cycle where mem_req = 1 and mem_ready = 1. mem_ready while mem_req = 0 is ignored.
- Reset asserted mid-instruction takes effect at the next edge and returns to FETCH. No partial register or PC write is issued in the reset cycle.

## Test plan
- Reset, then `add` with mem_ready tied high -> state sequence 0,1,2,4,0. reg_write pulses only in cycle 3, with reg_dst = 0 and alu_op = `OP_ADD`.
- LW with mem_ready low for 2 cycles in MEM -> 7 cycles total. WB asserts mem_to_reg = 1 and reg_dst = 1.
- BEQ with alu_zero = 1, then with alu_zero = 0 -> pc_write = 1 in EXEC for the first, 0 for the second. pc_src = 01 in both.
- BALZ with st_z = 0, then st_z = 1 -> no reg_write for the first. The second asserts pc_write, reg_write and write_reg31. Repeating with STATUS_BR = 0 -> illegal = 1 and state = 5.
- TIMEOUT = 4 with mem_ready held low in FETCH -> state = 5 and timeout = 1 after 4 wait cycles. With mem_ready rising on the 4th wait cycle -> DECODE, no fault.
- Reset asserted during MEM of SW -> mem_we = 0 in the reset cycle. Next cycle: state = 0 and fault flags clear.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/writeback for a shared-ALU datapath
module multicycle_control #(
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 255,
  parameter int STATUS_BR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic             mem_ready,
  input  logic             alu_zero,
  input  logic             st_z,
  input  logic             st_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             write_reg31,
  output logic             link,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
  localparam logic [5:0] O_R = 6'h00, O_J = 6'h02, O_JAL = 6'h03, O_BEQ = 6'h04, O_BNE = 6'h05;
  localparam logic [5:0] O_ADDI = 6'h08, O_ANDI = 6'h0c, O_ORI = 6'h0d, O_LW = 6'h23, O_SW = 6'h2b;
  localparam logic [5:0] O_BZ = 6'h14, O_BN = 6'h15, O_BALZ = 6'h16, O_BALN = 6'h17;
  localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_SLT = 3'd4;
  localparam bit SB = STATUS_BR != 0;
  localparam int CW = TIMEOUT < 1 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT < 1 ? 0 : TIMEOUT - 1);
  state_t state_q, nxt;
  logic [CW-1:0] cnt;
  logic [5:0] op, fn;
  logic unused_ok;
  logic is_r, r_alu, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne, is_addi, is_andi, is_ori;
  logic is_lw, is_sw, is_bz, is_bn, is_balz, is_baln, is_st, legal, taken, waiting, to_fault;
  logic [2:0] r_op;
  assign op = instr[WIDTH-1:WIDTH-6];
  assign fn = instr[5:0];
  assign unused_ok = ^instr[WIDTH-7:6];
  assign is_r = op == O_R;
  assign r_alu = is_r && (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT);
  assign is_jr = is_r && fn == F_JR;
  assign is_jalr = is_r && fn == F_JALR;
  assign is_j = op == O_J;
  assign is_jal = op == O_JAL;
  assign is_beq = op == O_BEQ;
  assign is_bne = op == O_BNE;
  assign is_addi = op == O_ADDI;
  assign is_andi = op == O_ANDI;
  assign is_ori = op == O_ORI;
  assign is_lw = op == O_LW;
  assign is_sw = op == O_SW;
  assign is_bz = SB && op == O_BZ;
  assign is_bn = SB && op == O_BN;
  assign is_balz = SB && op == O_BALZ;
  assign is_baln = SB && op == O_BALN;
  assign is_st = is_bz || is_bn || is_balz || is_baln;
  assign legal = r_alu || is_jr || is_jalr || is_j || is_jal || is_beq || is_bne || is_addi ||
                 is_andi || is_ori || is_lw || is_sw || is_st;
  assign taken = (is_bz || is_balz) ? st_z : st_n;
  assign r_op = fn == F_SUB ? OP_SUB : fn == F_AND ? OP_AND : fn == F_OR ? OP_OR :
                fn == F_SLT ? OP_SLT : OP_ADD;
  assign waiting = (state_q == FETCH || state_q == MEM) && !mem_ready;
  assign to_fault = TIMEOUT != 0 && waiting && cnt == LAST;
  assign state = state_q;
  // state register, memory wait counter and sticky fault causes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= nxt;
      cnt <= (waiting && nxt == state_q) ? cnt + 1'b1 : '0;
      illegal <= illegal || (state_q == DECODE && !legal);
      timeout <= timeout || to_fault;
    end
  end
  // next state and datapath controls, all strobes suppressed while reset is high
  always_comb begin
    nxt = state_q;
    {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst} = '0;
    {write_reg31, link, mem_to_reg, ext_op, alu_src_a} = '0;
    alu_src_b = 2'b00;
    alu_op = OP_ADD;
    pc_src = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? DECODE : to_fault ? FAULT : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op = 1'b1;
        if (!legal) nxt = FAULT;
        else if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_src = 2'b10;
          {reg_write, write_reg31, link} = {3{is_jal}};
          nxt = FETCH;
        end else if (is_jr || is_jalr) begin
          pc_write = 1'b1;
          pc_src = 2'b11;
          {reg_write, link} = {2{is_jalr}};
          nxt = FETCH;
        end else nxt = EXEC;
      end
      EXEC: begin
        if (r_alu) begin
          alu_src_a = 1'b1;
          alu_op = r_op;
          nxt = WB;
        end else if (is_addi || is_andi || is_ori) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op = is_addi;
          alu_op = is_andi ? OP_AND : is_ori ? OP_OR : OP_ADD;
          nxt = WB;
        end else if (is_lw || is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op = 1'b1;
          nxt = MEM;
        end else if (is_beq || is_bne) begin
          alu_src_a = 1'b1;
          alu_op = OP_SUB;
          pc_src = 2'b01;
          pc_write = is_beq ? alu_zero : !alu_zero;
          nxt = FETCH;
        end else if (is_st) begin
          pc_src = 2'b01;
          pc_write = taken;
          {reg_write, write_reg31, link} = {3{taken && (is_balz || is_baln)}};
          nxt = FETCH;
        end else nxt = FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        iord = 1'b1;
        mem_we = is_sw;
        nxt = mem_ready ? (is_sw ? FETCH : WB) : to_fault ? FAULT : MEM;
      end
      WB: begin
        reg_write = 1'b1;
        reg_dst = !is_r;
        mem_to_reg = is_lw;
        nxt = FETCH;
      end
      default: nxt = FAULT;
    endcase
    if (reset) begin
      {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst} = '0;
      {write_reg31, link, mem_to_reg, ext_op, alu_src_a} = '0;
      alu_src_b = 2'b00;
      alu_op = OP_ADD;
      pc_src = 2'b00;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven check of the multicycle control FSM across three parameterisations
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0, alu_zero = 1'b0, st_z = 1'b0, st_n = 1'b0;
  logic [31:0] instr = '0;
  logic mreq [3], mwe [3], iord [3], irw [3], pcw [3], rw [3], rdst [3], wr31 [3], lnk [3], m2r [3];
  logic ext [3], sa [3], ill [3], tmo [3];
  logic [1:0] sb [3], ps [3];
  logic [2:0] aop [3], st [3];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    multicycle_control #(.TIMEOUT(g == 1 ? 4 : 255), .STATUS_BR(g == 2 ? 0 : 1)) dut (
      .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .st_z(st_z), .st_n(st_n), .mem_req(mreq[g]), .mem_we(mwe[g]), .iord(iord[g]),
      .ir_write(irw[g]), .pc_write(pcw[g]), .reg_write(rw[g]), .reg_dst(rdst[g]),
      .write_reg31(wr31[g]), .link(lnk[g]), .mem_to_reg(m2r[g]), .ext_op(ext[g]),
      .alu_src_a(sa[g]), .alu_src_b(sb[g]), .alu_op(aop[g]), .pc_src(ps[g]), .state(st[g]),
      .illegal(ill[g]), .timeout(tmo[g])
    );
  end

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, OR = 3'd3;
  localparam logic [11:0] S_0 = 12'b000000000000, S_FR = 12'b100110000000, S_FW = 12'b100000000000;
  localparam logic [11:0] S_DE = 12'b000000000010, S_A = 12'b000000000001, S_AE = 12'b000000000011;
  localparam logic [11:0] S_WR = 12'b000001000000, S_WI = 12'b000001100000, S_WL = 12'b000001100100;
  localparam logic [11:0] S_ML = 12'b101000000000, S_MS = 12'b111000000000, S_BT = 12'b000010000001;
  localparam logic [11:0] S_ZL = 12'b000011011000, S_J = 12'b000010000010, S_JR = 12'b000011001010;
  localparam logic [11:0] S_JAL = 12'b000011011010;
  localparam logic [31:0] I_ADD = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_LW = {6'h23, 5'd1, 5'd2, 16'd8};
  localparam logic [31:0] I_SW = {6'h2b, 5'd1, 5'd2, 16'd12};
  localparam logic [31:0] I_BEQ = {6'h04, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] I_BALZ = {6'h16, 26'd4};
  localparam logic [31:0] I_J = {6'h02, 26'd16};
  localparam logic [31:0] I_JAL = {6'h03, 26'd20};
  localparam logic [31:0] I_JALR = {6'h00, 5'd4, 5'd0, 5'd31, 5'd0, 6'h09};
  localparam logic [31:0] I_ORI = {6'h0d, 5'd1, 5'd2, 16'hff00};
  localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd2, 16'hfffc};
  localparam logic [31:0] I_BAD = {6'h3f, 26'd0};

  typedef struct {
    int d;
    bit c;
    logic r;
    logic [31:0] i;
    logic [3:0] f;
    logic [23:0] x;
  } vec_t;
  vec_t v[$];

  function automatic logic [23:0] e(input logic [2:0] s, input logic [11:0] m, input logic [1:0] b,
                                    input logic [2:0] o, input logic [1:0] p, input logic il, input logic t);
    return {s, m, b, o, p, il, t};
  endfunction

  function automatic logic [23:0] act(input int d);
    return {st[d], mreq[d], mwe[d], iord[d], irw[d], pcw[d], rw[d], rdst[d], wr31[d], lnk[d], m2r[d],
            ext[d], sa[d], sb[d], aop[d], ps[d], ill[d], tmo[d]};
  endfunction

  task automatic t(input int d, input bit c, input logic r, input logic [31:0] i, input logic [3:0] f,
                   input logic [23:0] x);
    v.push_back('{d, c, r, i, f, x});
  endtask

  task automatic check(input int d, input logic [23:0] x, input string nm);
    logic [23:0] a;
    a = act(d);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, a, x);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] i, input logic [3:0] f);
    reset = r;
    instr = i;
    {mem_ready, alu_zero, st_z, st_n} = f;
  endtask

  initial begin
    t(0, 1, 1, I_ADD,  4'b1000, e(0, S_0,  2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_ADD,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_ADD,  4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_ADD,  4'b1000, e(2, S_A,  2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_ADD,  4'b1000, e(4, S_WR, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b1000, e(2, S_AE, 2'b10, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b0000, e(3, S_ML, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b0000, e(3, S_ML, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b1000, e(3, S_ML, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_LW,   4'b1000, e(4, S_WL, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BEQ,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BEQ,  4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BEQ,  4'b1100, e(2, S_BT, 2'b00, SUB, 2'b01, 0, 0));
    t(0, 1, 0, I_BEQ,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BEQ,  4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BEQ,  4'b1000, e(2, S_A,  2'b00, SUB, 2'b01, 0, 0));
    t(0, 1, 0, I_BALZ, 4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BALZ, 4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BALZ, 4'b1001, e(2, S_0,  2'b00, ADD, 2'b01, 0, 0));
    t(0, 1, 0, I_BALZ, 4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BALZ, 4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BALZ, 4'b1010, e(2, S_ZL, 2'b00, ADD, 2'b01, 0, 0));
    t(0, 1, 0, I_SW,   4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_SW,   4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_SW,   4'b1000, e(2, S_AE, 2'b10, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_SW,   4'b0000, e(3, S_MS, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 1, I_SW,   4'b1000, e(3, S_0,  2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_SW,   4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_J,    4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_J,    4'b1000, e(1, S_J,  2'b11, ADD, 2'b10, 0, 0));
    t(0, 1, 0, I_JALR, 4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_JALR, 4'b1000, e(1, S_JR, 2'b11, ADD, 2'b11, 0, 0));
    t(0, 1, 0, I_BAD,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BAD,  4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_BAD,  4'b1000, e(5, S_0,  2'b00, ADD, 2'b00, 1, 0));
    t(0, 1, 0, I_ADD,  4'b1000, e(5, S_0,  2'b00, ADD, 2'b00, 1, 0));
    t(0, 0, 1, I_ORI,  4'b1000, '0);
    t(0, 1, 0, I_ORI,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_ORI,  4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_ORI,  4'b1000, e(2, S_A,  2'b10, OR,  2'b00, 0, 0));
    t(0, 1, 0, I_ORI,  4'b1000, e(4, S_WI, 2'b00, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_JAL,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(0, 1, 0, I_JAL,  4'b1000, e(1, S_JAL, 2'b11, ADD, 2'b10, 0, 0));
    t(0, 1, 0, I_JAL,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 0, 1, I_ADD,  4'b0000, '0);
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b1000, e(5, S_0,  2'b00, ADD, 2'b00, 0, 1));
    t(1, 0, 1, I_ADD,  4'b0000, '0);
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b0000, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(1, 1, 0, I_ADD,  4'b1000, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(2, 0, 1, I_BALZ, 4'b1000, '0);
    t(2, 1, 0, I_BALZ, 4'b1000, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0));
    t(2, 1, 0, I_BALZ, 4'b1010, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0));
    t(2, 1, 0, I_BALZ, 4'b1010, e(5, S_0,  2'b00, ADD, 2'b00, 1, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    foreach (v[k]) begin
      step(v[k].r, v[k].i, v[k].f);
      #1;
      if (v[k].c) check(v[k].d, v[k].x, $sformatf("vec%0d", k));
      @(posedge clk); #1;
    end
    step(1'b1, I_ADDI, 4'b1000);
    @(posedge clk); #1;
    step(1'b0, I_ADDI, 4'b0000);
    #1 check(0, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0), "addi_fetch_wait");
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1 check(0, e(0, S_FR, 2'b01, ADD, 2'b00, 0, 0), "addi_fetch_done");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1 check(0, e(1, S_DE, 2'b11, ADD, 2'b00, 0, 0), "addi_decode");
    @(posedge clk); #1;
    #1 check(0, e(2, S_AE, 2'b10, ADD, 2'b00, 0, 0), "addi_exec");
    @(posedge clk); #1;
    #1 check(0, e(4, S_WI, 2'b00, ADD, 2'b00, 0, 0), "addi_wb");
    @(posedge clk); #1;
    #1 check(0, e(0, S_FW, 2'b01, ADD, 2'b00, 0, 0), "addi_next_fetch");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
